// File: rtl/cdec_pkg.sv
// CDEC teaching CPU shared definitions.
// Widths, opcodes and seven-segment glyphs.
package cdec_pkg;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 4;
    localparam int MEM_DEPTH = 16;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_LD  = 4'h2;
    localparam logic [3:0] OP_ST  = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_SUB = 4'h5;
    localparam logic [3:0] OP_AND = 4'h6;
    localparam logic [3:0] OP_OR  = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_JC  = 4'hA;
    localparam logic [3:0] OP_IN  = 4'hB;
    localparam logic [3:0] OP_OUT = 4'hC;
    localparam logic [3:0] OP_SHL = 4'hD;
    localparam logic [3:0] OP_SHR = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_A    = 7'b0001000;
    localparam logic [6:0] SEG_B    = 7'b0000011;
    localparam logic [6:0] SEG_C    = 7'b1000110;
    localparam logic [6:0] SEG_D    = 7'b0100001;
    localparam logic [6:0] SEG_E    = 7'b0000110;
    localparam logic [6:0] SEG_F    = 7'b0001110;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        logic [6:0] g;
        unique case (v)
            4'h0: g = SEG_0;
            4'h1: g = SEG_1;
            4'h2: g = SEG_2;
            4'h3: g = SEG_3;
            4'h4: g = SEG_4;
            4'h5: g = SEG_5;
            4'h6: g = SEG_6;
            4'h7: g = SEG_7;
            4'h8: g = SEG_8;
            4'h9: g = SEG_9;
            4'hA: g = SEG_A;
            4'hB: g = SEG_B;
            4'hC: g = SEG_C;
            4'hD: g = SEG_D;
            4'hE: g = SEG_E;
            4'hF: g = SEG_F;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/cdec_cpu_shell_hex7seg.sv
// Hex nibble to active-low seven-segment glyph.
// Pure combinational lookup.
module hex7seg
    import cdec_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    assign seg = hex_glyph(value);

endmodule

// File: rtl/cdec_cpu_shell.sv
// CDEC board top: loader, program RAM, accumulator CPU, displays.
// Everything is clocked by BUTTON[2]; BUTTON[1] is a synchronous reset.
module cdec_cpu_shell
    import cdec_pkg::*;
(
    input  logic [2:0] BUTTON,
    input  logic [9:0] SW,
    output logic [9:0] LEDG,
    output logic [6:0] HEX0_D,
    output logic [6:0] HEX1_D,
    output logic [6:0] HEX2_D,
    output logic [6:0] HEX3_D,
    output logic       HEX0_DP,
    output logic       HEX1_DP,
    output logic       HEX2_DP,
    output logic       HEX3_DP
);

    logic clk;
    logic rst_n;
    logic run;
    logic sel;

    assign clk   = BUTTON[2];
    assign rst_n = BUTTON[1];
    assign run   = SW[9];
    assign sel   = SW[8];

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    logic [ADDR_W-1:0] pc, pc_n, ptr;
    logic [DATA_W-1:0] acc, acc_n;
    logic [DATA_W-1:0] io_out, io_n;
    logic              z, z_n, c, c_n;
    logic              halted, halted_n;

    logic s1, s2, prev, deposit;
    logic cpu_en;

    logic [DATA_W-1:0] ir, opd;
    logic [3:0]        op;
    logic [ADDR_W-1:0] arg;
    logic [DATA_W:0]   sum, diff;

    logic              st_req, upd_z;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;

    // Bring the step button into the clock domain and keep one history bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= BUTTON[0];
            s2   <= s1;
            prev <= s2;
        end
    end

    assign deposit = s2 & ~prev;
    assign cpu_en  = run & ~halted;

    assign ir   = mem[pc];
    assign op   = ir[7:4];
    assign arg  = ir[3:0];
    assign opd  = mem[arg];
    assign sum  = {1'b0, acc} + {1'b0, opd};
    assign diff = {1'b0, acc} - {1'b0, opd};

    // Decode and execute the fetched instruction.
    always_comb begin
        pc_n     = pc;
        acc_n    = acc;
        z_n      = z;
        c_n      = c;
        io_n     = io_out;
        halted_n = halted;
        st_req   = 1'b0;
        upd_z    = 1'b0;
        if (cpu_en) begin
            pc_n = pc + 1'b1;
            unique case (op)
                OP_NOP: ;
                OP_LDI: acc_n = {4'h0, arg};
                OP_LD:  acc_n = opd;
                OP_ST:  st_req = 1'b1;
                OP_ADD: begin
                    acc_n = sum[DATA_W-1:0];
                    c_n   = sum[DATA_W];
                    upd_z = 1'b1;
                end
                OP_SUB: begin
                    acc_n = diff[DATA_W-1:0];
                    c_n   = ~diff[DATA_W];
                    upd_z = 1'b1;
                end
                OP_AND: begin
                    acc_n = acc & opd;
                    upd_z = 1'b1;
                end
                OP_OR: begin
                    acc_n = acc | opd;
                    upd_z = 1'b1;
                end
                OP_JMP: pc_n = arg;
                OP_JZ:  if (z) pc_n = arg;
                OP_JC:  if (c) pc_n = arg;
                OP_IN: begin
                    acc_n = SW[7:0];
                    upd_z = 1'b1;
                end
                OP_OUT: io_n = acc;
                OP_SHL: begin
                    acc_n = {acc[DATA_W-2:0], 1'b0};
                    c_n   = acc[DATA_W-1];
                    upd_z = 1'b1;
                end
                OP_SHR: begin
                    acc_n = {1'b0, acc[DATA_W-1:1]};
                    c_n   = acc[0];
                    upd_z = 1'b1;
                end
                OP_HLT: begin
                    halted_n = 1'b1;
                    pc_n     = pc;
                end
            endcase
            if (upd_z) z_n = (acc_n == '0);
        end
    end

    // Run mode stores from the CPU, program mode deposits from switches.
    assign mem_we = run ? (cpu_en & st_req) : deposit;
    assign mem_wa = run ? arg : ptr;
    assign mem_wd = run ? acc : SW[7:0];

    // Program RAM; contents survive reset, but reset blocks the write.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) mem[mem_wa] <= mem_wd;
    end

    // CPU architectural state and load pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc     <= '0;
            acc    <= '0;
            z      <= 1'b0;
            c      <= 1'b0;
            halted <= 1'b0;
            io_out <= '0;
            ptr    <= '0;
        end else begin
            pc     <= pc_n;
            acc    <= acc_n;
            z      <= z_n;
            c      <= c_n;
            halted <= halted_n;
            io_out <= io_n;
            if (!run && deposit) ptr <= ptr + 1'b1;
        end
    end

    logic [3:0]        d3, d2;
    logic [DATA_W-1:0] dbyte;
    logic              dash;
    logic [6:0]        g2;

    // Pick what each digit shows from mode and select switch.
    always_comb begin
        d3    = pc;
        d2    = {2'b00, c, z};
        dbyte = acc;
        dash  = 1'b0;
        unique case (1'b1)
            (!run && !sel): begin
                d3    = ptr;
                dash  = 1'b1;
                dbyte = SW[7:0];
            end
            (!run && sel): begin
                d3    = ptr;
                dash  = 1'b1;
                dbyte = mem[ptr];
            end
            (run && sel): begin
                dash  = 1'b1;
                dbyte = mem[pc];
            end
            (run && !sel): ;
        endcase
    end

    hex7seg u_hex3 (.value(d3),         .seg(HEX3_D));
    hex7seg u_hex2 (.value(d2),         .seg(g2));
    hex7seg u_hex1 (.value(dbyte[7:4]), .seg(HEX1_D));
    hex7seg u_hex0 (.value(dbyte[3:0]), .seg(HEX0_D));

    assign HEX2_D  = dash ? SEG_DASH : g2;
    assign HEX3_DP = ~run;
    assign HEX2_DP = 1'b1;
    assign HEX1_DP = 1'b1;
    assign HEX0_DP = ~halted;
    assign LEDG    = {clk, halted, io_out};

endmodule

// File: tb/tb_cdec_cpu_shell.sv
// Randomized and directed bench for cdec_cpu_shell.
// A behavioural ISA model predicts every display and LED each cycle.
module tb_cdec_cpu_shell;

    logic       clk;
    logic       rst_n;
    logic       step;
    logic [9:0] SW;
    wire  [2:0] BUTTON = {clk, rst_n, step};
    wire  [9:0] LEDG;
    wire  [6:0] HEX0_D, HEX1_D, HEX2_D, HEX3_D;
    wire        HEX0_DP, HEX1_DP, HEX2_DP, HEX3_DP;

    cdec_cpu_shell dut (
        .BUTTON(BUTTON), .SW(SW), .LEDG(LEDG),
        .HEX0_D(HEX0_D), .HEX1_D(HEX1_D),
        .HEX2_D(HEX2_D), .HEX3_D(HEX3_D),
        .HEX0_DP(HEX0_DP), .HEX1_DP(HEX1_DP),
        .HEX2_DP(HEX2_DP), .HEX3_DP(HEX3_DP)
    );

    localparam logic [6:0] GLY [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    localparam logic [6:0] DASH = 7'b0111111;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;
    bit mem_ok   = 0;

    logic [3:0] m_pc, m_ptr;
    logic [7:0] m_acc, m_io;
    bit         m_z, m_c, m_halt;
    logic [7:0] m_mem [16];
    bit         h1, h2, h3;

    task automatic chk(input string nm, input logic [9:0] act,
                       input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ISA-level reference model, advanced on each rising edge.
    always @(posedge clk) begin : model
        bit         dep;
        logic [7:0] ir, md;
        logic [3:0] a, npc;
        int         t;
        if (!rst_n) begin
            m_pc = 0; m_acc = 0; m_z = 0; m_c = 0;
            m_halt = 0; m_io = 0; m_ptr = 0;
            h1 = 0; h2 = 0; h3 = 0;
        end else begin
            dep = h2 && !h3;
            h3 = h2; h2 = h1; h1 = step;
            if (!SW[9]) begin
                if (dep) begin
                    m_mem[m_ptr] = SW[7:0];
                    m_ptr = 4'((int'(m_ptr) + 1) % 16);
                end
            end else if (!m_halt) begin
                ir  = m_mem[m_pc];
                a   = ir[3:0];
                md  = m_mem[a];
                npc = 4'((int'(m_pc) + 1) % 16);
                case (int'(ir[7:4]))
                    1:  m_acc = 8'(int'(a));
                    2:  m_acc = md;
                    3:  m_mem[a] = m_acc;
                    4: begin
                        t = int'(m_acc) + int'(md);
                        m_c = (t > 255);
                        m_acc = 8'(t % 256);
                        m_z = (m_acc == 0);
                    end
                    5: begin
                        t = int'(m_acc) - int'(md);
                        m_c = (t >= 0);
                        m_acc = 8'((t + 256) % 256);
                        m_z = (m_acc == 0);
                    end
                    6: begin m_acc = m_acc & md; m_z = (m_acc == 0); end
                    7: begin m_acc = m_acc | md; m_z = (m_acc == 0); end
                    8:  npc = a;
                    9:  if (m_z) npc = a;
                    10: if (m_c) npc = a;
                    11: begin m_acc = SW[7:0]; m_z = (m_acc == 0); end
                    12: m_io = m_acc;
                    13: begin
                        t = int'(m_acc) * 2;
                        m_c = (t > 255);
                        m_acc = 8'(t % 256);
                        m_z = (m_acc == 0);
                    end
                    14: begin
                        m_c = (int'(m_acc) % 2) == 1;
                        m_acc = 8'(int'(m_acc) / 2);
                        m_z = (m_acc == 0);
                    end
                    15: begin m_halt = 1; npc = m_pc; end
                    default: ;
                endcase
                m_pc = npc;
            end
        end
    end

    // Compare every output against the model while the clock is low.
    always @(negedge clk) begin : compare
        logic [3:0] e3;
        logic [6:0] e2;
        logic [7:0] eb;
        if (chk_en) begin
            e3 = SW[9] ? m_pc : m_ptr;
            e2 = (!SW[9] || SW[8]) ? DASH
                 : GLY[int'(m_c) * 2 + int'(m_z)];
            eb = !SW[9] ? (SW[8] ? m_mem[m_ptr] : SW[7:0])
                        : (SW[8] ? m_mem[m_pc] : m_acc);
            chk("ledg", LEDG, {1'b0, m_halt, m_io});
            chk("hex3", {3'b0, HEX3_D}, {3'b0, GLY[e3]});
            chk("hex2", {3'b0, HEX2_D}, {3'b0, e2});
            chk("dp", {6'b0, HEX3_DP, HEX2_DP, HEX1_DP, HEX0_DP},
                {6'b0, !SW[9], 1'b1, 1'b1, !m_halt});
            if (mem_ok || (!SW[9] && !SW[8])) begin
                chk("hex1", {3'b0, HEX1_D}, {3'b0, GLY[eb[7:4]]});
                chk("hex0", {3'b0, HEX0_D}, {3'b0, GLY[eb[3:0]]});
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
        #2;
    endtask

    task automatic deposit(input logic [7:0] b);
        SW[7:0] = b;
        step = 1'b1;
        cyc($urandom_range(1, 4));
        step = 1'b0;
        cyc($urandom_range(3, 5));
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
    endtask

    localparam logic [7:0] FLAGS [16] = '{
        8'h1F, 8'hD0, 8'hD0, 8'hD0, 8'hD0, 8'h4F, 8'h98, 8'hF0,
        8'hAA, 8'hF0, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10};

    initial begin
        rst_n = 1'b0;
        step  = 1'b0;
        SW    = '0;
        cyc(1);
        chk_en = 1;
        chk("rst_ledg", LEDG, 10'h000);
        chk("rst_hex3", {3'b0, HEX3_D}, {3'b0, 7'b1000000});
        rst_n = 1'b1;

        deposit(8'h13); deposit(8'h44); deposit(8'hC0);
        deposit(8'hF0); deposit(8'h05);
        chk("ptr5", {3'b0, HEX3_D}, {3'b0, 7'b0010010});
        for (int i = 0; i < 11; i++) deposit(8'($urandom));
        mem_ok = 1;
        SW[8] = 1'b1;
        cyc(1);
        chk("wrap_hi", {3'b0, HEX1_D}, {3'b0, 7'b1111001});
        chk("wrap_lo", {3'b0, HEX0_D}, {3'b0, 7'b0110000});

        do_reset();
        chk("keep_hi", {3'b0, HEX1_D}, {3'b0, 7'b1111001});
        chk("keep_lo", {3'b0, HEX0_D}, {3'b0, 7'b0110000});
        for (int i = 0; i < 16; i++) deposit(m_mem[m_ptr]);

        SW = 10'h200;
        cyc(6);
        chk("run_io", {2'b0, LEDG[7:0]}, 10'h008);
        chk("run_halt", {9'b0, LEDG[8]}, 10'h001);
        chk("run_hi", {3'b0, HEX1_D}, {3'b0, 7'b1000000});
        chk("run_lo", {3'b0, HEX0_D}, {3'b0, 7'b0000000});
        chk("run_pc", {3'b0, HEX3_D}, {3'b0, 7'b0110000});

        SW = 10'h000;
        do_reset();
        for (int i = 0; i < 16; i++) deposit(FLAGS[i]);
        SW = 10'h200;
        cyc(12);
        chk("flg_cz", {3'b0, HEX2_D}, {3'b0, 7'b0110000});
        chk("flg_pc", {3'b0, HEX3_D}, {3'b0, 7'b0001000});
        chk("flg_acc", {3'b0, HEX0_D}, {3'b0, 7'b1000000});

        SW = 10'h000;
        do_reset();
        deposit(8'hB0); deposit(8'hC0); deposit(8'h80);
        SW = 10'h2A5;
        cyc(8);
        chk("in_out", {2'b0, LEDG[7:0]}, 10'h0A5);

        SW = 10'h000;
        do_reset();
        for (int i = 0; i < 16; i++) deposit(8'h00);
        SW = 10'h200;
        cyc(20);
        chk("nop_pc", {3'b0, HEX3_D}, {3'b0, 7'b0011001});
        @(posedge clk);
        #1;
        chk("clk_led", {9'b0, LEDG[9]}, 10'h001);
        cyc(0);

        step = 1'b1;
        do_reset();
        chk("mid_pc", {3'b0, HEX3_D}, {3'b0, 7'b1000000});
        chk("mid_halt", {9'b0, LEDG[8]}, 10'h000);
        cyc(4);
        SW = 10'h000;
        cyc(4);
        chk("no_dep", {3'b0, HEX3_D}, {3'b0, 7'b1000000});
        step = 1'b0;
        cyc(3);

        for (int i = 0; i < 300; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            rst_n = (r >= 5);
            if (r >= 5 && r < 25) SW[9] = ~SW[9];
            SW[8]   = 1'($urandom_range(0, 1));
            SW[7:0] = 8'($urandom);
            if (r >= 25 && r < 55) step = ~step;
            cyc($urandom_range(1, 3));
        end
        rst_n = 1'b1;
        cyc(2);

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
